// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: holds the cipher state, steps an
// external combinational round datapath through NR rounds, hands out ciphertext.
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] round_key,
    output logic [127:0] rnd_in,
    output logic         rnd_last,
    input  logic [127:0] rnd_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    logic [1:0]   state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [3:0]   idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    blk_d   = in_block;
                    idx_d   = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (rk_valid) begin
                    blk_d   = blk_q ^ round_key;
                    idx_d   = 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                // rk_idx stays at NR through DONE; it is cleared only on the way back to IDLE
                if (rk_valid) begin
                    blk_d = rnd_out;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign rnd_last  = (state_q == S_ROUND) && (idx_q == LAST_IDX);
    assign rk_idx    = idx_q;
    assign rnd_in    = blk_q;
    assign out_block = blk_q;

endmodule
